// File: rtl/alu_arbiter_if.sv
// Request/response channel bundle between the issue clients and alu_arbiter.
// slave = arbiter side, master = client side.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*5-1:0]  req_shamt;
  logic [NREQ*4-1:0]  req_funct;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_shamt, req_funct, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_shamt, req_funct, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit ALU between NREQ requesters;
// results return on a common response channel tagged with the requester id.
//
// state | meaning
// IDLE  | searching for a request, req_ready asserted toward the winner
// EXEC  | alu_funct driven for one cycle, ALU registers result at cycle end
// WAIT  | ALU result captured into the response register
// RESP  | response held until the consumer accepts it
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [31:0]  alu_a,
  output logic [31:0]  alu_b,
  output logic [4:0]   alu_shamt,
  output logic [3:0]   alu_funct,
  input  logic [31:0]  alu_res,
  output logic         busy,
  output logic [15:0]  op_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, r_id, w_gnt_id;
  logic            w_gnt_found, w_accept;
  logic [3:0]      r_funct, w_gnt_funct, w_alu_funct;
  logic [31:0]     r_alu_a, r_alu_b, r_rsp_data;
  logic [4:0]      r_alu_shamt;
  logic            r_rsp_err;
  logic [15:0]     r_op_count;
  logic [NREQ-1:0] w_req_ready;

  // Search starts one past the last winner so every client gets a turn.
  always_comb begin : arb
    int             sum;
    logic [IDW-1:0] idx;
    sum         = 0;
    idx         = '0;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = int'(r_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!w_gnt_found && bus.req_valid[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = idx;
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_gnt_found;
  assign w_gnt_funct = bus.req_funct[w_gnt_id*4 +: 4];

  always_comb begin
    w_req_ready = '0;
    if (w_accept) w_req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alu_funct = '0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_gnt_funct == 4'd0) ? S_RESP : S_EXEC;
      S_EXEC: begin
        w_alu_funct = r_funct;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: w_state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(NREQ-1);
      r_id        <= '0;
      r_funct     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_shamt <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_ptr   <= w_gnt_id;
        r_id    <= w_gnt_id;
        r_funct <= w_gnt_funct;
        // Illegal requests bypass the ALU entirely; its inputs keep their values.
        if (w_gnt_funct == 4'd0) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_alu_a     <= bus.req_a[w_gnt_id*32 +: 32];
          r_alu_b     <= bus.req_b[w_gnt_id*32 +: 32];
          r_alu_shamt <= bus.req_shamt[w_gnt_id*5 +: 5];
        end
      end
      if (r_state == S_WAIT) begin
        r_rsp_data <= alu_res;
        r_rsp_err  <= 1'b0;
      end
      if (r_state == S_RESP && bus.rsp_ready) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_shamt     = r_alu_shamt;
  assign alu_funct     = w_alu_funct;
  assign busy          = (r_state != S_IDLE);
  assign op_count      = r_op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in registered ALU, a transaction-level model
// checked every cycle on the falling edge, and directed scenarios with literals.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_res = '0;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_res(alu_res), .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                         logic [4:0] sh, logic [3:0] f);
    case (f)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      4'd15:   return 32'($countones(a));
      default: return ~a;
    endcase
  endfunction

  // Stand-in ALU: registers a result whenever funct is nonzero, holds otherwise.
  always @(posedge clk)
    if (alu_funct != 4'd0) alu_res <= alu_fn(alu_a, alu_b, alu_shamt, alu_funct);

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, response visible after a fixed age.
  bit          m_active = 0;
  int          m_age = 0;
  int          m_ptr = NREQ-1;
  int          m_id = 0;
  logic [31:0] m_data = '0, m_a = '0, m_b = '0;
  logic [4:0]  m_sh = '0;
  logic [3:0]  m_funct = '0;
  bit          m_err = 0;
  logic [15:0] m_ops = '0;
  int          cyc = 0;
  bit          seen_funct = 0;
  int          g_log[$];
  int          g_cyc[$];
  logic [31:0] r_log[$];
  int          r_id_log[$];

  always @(negedge clk) begin
    cyc++;
    if (alu_funct != 4'd0) seen_funct = 1;
    if (!rst_n) begin
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_shamt", alu_shamt, 0);
      chk("rst_alu_funct", alu_funct, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      m_active = 0;
      m_ptr    = NREQ-1;
      m_ops    = '0;
    end else begin
      int              g;
      logic [NREQ-1:0] er;
      bit              ev;
      g = -1;
      if (!m_active)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = m_active && (m_age >= (m_err ? 1 : 3));
      chk("req_ready", bus.req_ready, er);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("busy", busy, m_active);
      chk("op_count", op_count, m_ops);
      chk("alu_funct", alu_funct, (m_active && !m_err && m_age == 1) ? m_funct : 4'd0);
      if (m_active && !m_err && m_age == 1) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_shamt", alu_shamt, m_sh);
      end
      if (ev) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (ev && bus.rsp_ready) begin
        m_active = 0;
        m_ops    = m_ops + 16'd1;
        r_log.push_back(bus.rsp_data);
        r_id_log.push_back(int'(bus.rsp_id));
      end else if (m_active) begin
        m_age++;
      end else if (g >= 0) begin
        m_active = 1;
        m_age    = 1;
        m_id     = g;
        m_a      = bus.req_a[32*g +: 32];
        m_b      = bus.req_b[32*g +: 32];
        m_sh     = bus.req_shamt[5*g +: 5];
        m_funct  = bus.req_funct[4*g +: 4];
        m_err    = (m_funct == 4'd0);
        m_data   = m_err ? 32'd0 : alu_fn(m_a, m_b, m_sh, m_funct);
        m_ptr    = g;
        g_log.push_back(g);
        g_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [4:0] sh, logic [3:0] f);
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
    bus.req_shamt[5*i +: 5] = sh;
    bus.req_funct[4*i +: 4] = f;
    bus.req_valid[i]        = 1'b1;
  endtask

  // Returns just after the edge on which requester id was accepted.
  task automatic wait_hs(int id);
    bit got;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      #1;
      if (bus.req_ready[id]) got = 1;
      @(posedge clk);
      #1;
    end
    chk("hs_timeout", got, 1);
  endtask

  task automatic rsp_lat(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_shamt = '0;
    bus.req_funct = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADD 5+7 from requester 0
    bus.rsp_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, 5'd0, 4'd1);
    wait_hs(0);
    bus.req_valid = '0;
    rsp_lat(lat);
    chk("add_latency", lat, 2);
    chk("add_data", bus.rsp_data, 32'd12);
    chk("add_id", bus.rsp_id, 0);
    chk("add_err", bus.rsp_err, 0);
    tick();
    chk("add_op_count", op_count, 16'd1);

    // All four requesting SUB 100-i
    do_reset();
    g_log.delete(); g_cyc.delete(); r_log.delete(); r_id_log.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd100, 32'(i), 5'd0, 4'd2);
    n = 0;
    while (g_log.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    chk("rr_grants", g_log.size(), 5);
    chk("rr_rsps", r_log.size(), 5);
    if (g_log.size() == 5 && r_log.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", g_log[k], k % 4);
        chk("rr_data", r_log[k], 32'(100 - (k % 4)));
        if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 4);
      end

    // SLA 1<<4 from requester 2 with back-pressure
    bus.rsp_ready = 1'b0;
    set_req(2, 32'd1, 32'd0, 5'd4, 4'd8);
    wait_hs(2);
    bus.req_valid = '0;
    set_req(0, 32'd3, 32'd4, 5'd0, 4'd1);
    rsp_lat(lat);
    chk("sla_latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, 32'd16);
      chk("hold_id", bus.rsp_id, 2);
      chk("hold_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    wait_hs(0);
    bus.req_valid = '0;
    wait_idle();

    // Illegal funct 0 from requester 1
    seen_funct = 0;
    set_req(1, 32'd9, 32'd9, 5'd0, 4'd0);
    wait_hs(1);
    bus.req_valid = '0;
    rsp_lat(lat);
    chk("ill_latency", lat, 0);
    chk("ill_err", bus.rsp_err, 1);
    chk("ill_data", bus.rsp_data, 0);
    chk("ill_id", bus.rsp_id, 1);
    wait_idle();
    chk("ill_alu_idle", seen_funct, 0);

    // HAM from requester 3 aborted by reset during EXEC
    do_reset();
    set_req(3, 32'hFFFF_FFFF, 32'd0, 5'd0, 4'd15);
    wait_hs(3);
    chk("ham_exec_funct", alu_funct, 4'd15);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_funct", alu_funct, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    chk("abort_data", bus.rsp_data, 0);
    tick();
    rst_n = 1'b1;
    g_log.delete(); r_log.delete(); r_id_log.delete();
    set_req(0, 32'd1, 32'd1, 5'd0, 4'd1);
    set_req(3, 32'hFFFF_FFFF, 32'd0, 5'd0, 4'd15);
    n = 0;
    while (g_log.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    bus.req_valid[0] = 1'b0;
    n = 0;
    while (r_log.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    chk("post_rst_rsps", r_log.size(), 2);
    if (r_log.size() == 2) begin
      chk("post_rst_first_id", r_id_log[0], 0);
      chk("post_rst_first_data", r_log[0], 32'd2);
      chk("post_rst_ham_id", r_id_log[1], 3);
      chk("post_rst_ham_data", r_log[1], 32'd32);
    end

    // op_count wrap
    force dut.r_op_count = 16'hFFFF;
    m_ops = 16'hFFFF;
    tick();
    release dut.r_op_count;
    tick();
    chk("wrap_pre", op_count, 16'hFFFF);
    set_req(1, 32'd2, 32'd3, 5'd0, 4'd1);
    wait_hs(1);
    bus.req_valid = '0;
    wait_idle();
    chk("wrap_post", op_count, 16'h0000);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
